// File: rtl/spw_avmm_pio_ctrl.sv
// Avalon-MM slave PIO for SpaceWire link control/status lines.
//
// Output side: WIDTH-bit data register with atomic set/clear (OUTSET/OUTCLR) and a
// self-timed pulse engine that inverts selected bits for PULSE_CYCLES cycles.
// Input side: SYNC_STAGES-deep synchroniser, rising-edge capture (W1C) and a maskable
// level interrupt.
//
// Optional build macro: SPW_PIO_BOTHEDGE_EN adds a per-bit EDGE_SEL register at
// address 7 (0 = rising edge, 1 = both edges). Without it, address 7 is reserved.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   address, chipselect,   Avalon-MM slave: word address, select,
//   write_n, writedata     active-low write strobe, write data
//   readdata               combinational read data (zero wait states)
//   in_port                asynchronous status inputs
//   out_port               control outputs
//   irq                    level interrupt, active-high
module spw_avmm_pio_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [31:0] RESET_VALUE  = 32'h0000_0001,
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic {StIdle, StActive} pulse_state_e;

  pulse_state_e     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_sync, edge_det;
  logic             busy;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];

`ifdef SPW_PIO_BOTHEDGE_EN
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;

  always_comb begin
    edge_sel_d = edge_sel_q;
    if (wr_en && address == 3'd7) edge_sel_d = wd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_sel_q <= '0;
    else          edge_sel_q <= edge_sel_d;
  end

  assign edge_det = (in_sync & ~prev_q & ~edge_sel_q) | ((in_sync ^ prev_q) & edge_sel_q);
`else
  assign edge_det = in_sync & ~prev_q;
`endif

  // Register-file next state; address decode makes the write cases exclusive.
  always_comb begin
    data_d     = data_q;
    irq_mask_d = irq_mask_q;
    edge_d     = edge_q;
    if (wr_en) begin
      case (address)
        3'd0:    data_d     = wd;
        3'd2:    irq_mask_d = wd;
        3'd3:    edge_d     = edge_q & ~wd;
        3'd4:    data_d     = data_q | wd;
        3'd5:    data_d     = data_q & ~wd;
        default: ;
      endcase
    end
    // Applied after the W1C so a coincident edge wins.
    edge_d = edge_d | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      irq_mask_q <= '0;
      edge_q     <= '0;
      prev_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      data_q     <= data_d;
      irq_mask_q <= irq_mask_d;
      edge_q     <= edge_d;
      prev_q     <= in_sync;
      sync_q[0]  <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Pulse FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pmask_q <= pmask_d;
    end
  end

  // Pulse FSM: next state. A non-zero PULSE write (re)loads from either state, so
  // bits shared by the old and new mask stay inverted without a gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pmask_d = pmask_q;
    if (wr_en && address == 3'd6 && wd != '0) begin
      state_d = StActive;
      cnt_d   = CntW'(PULSE_CYCLES);
      pmask_d = wd;
    end else if (state_q == StActive) begin
      if (cnt_q == CntW'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
        pmask_d = '0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Pulse FSM: outputs. Purely from registers, so reset forces out_port immediately.
  always_comb begin
    busy     = (state_q == StActive);
    out_port = data_q ^ (busy ? pmask_q : '0);
  end

  assign irq = |(edge_q & irq_mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(data_q);
      3'd1: readdata = 32'(in_sync);
      3'd2: readdata = 32'(irq_mask_q);
      3'd3: readdata = 32'(edge_q);
      3'd6: begin
        readdata     = 32'(pmask_q);
        readdata[31] = readdata[31] | busy;
      end
`ifdef SPW_PIO_BOTHEDGE_EN
      3'd7: readdata = 32'(edge_sel_q);
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spw_avmm_pio_ctrl.sv
// Directed bench for spw_avmm_pio_ctrl (WIDTH=8, RESET_VALUE=8'h01, PULSE_CYCLES=16,
// SYNC_STAGES=2). Inputs change on the falling edge; outputs are sampled there too.
module tb_spw_avmm_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int c;
  logic [31:0] rv;

  spw_avmm_pio_ctrl #(
    .WIDTH        (8),
    .RESET_VALUE  (32'h0000_0001),
    .PULSE_CYCLES (16),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge and the task
  // returns at the following falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset state and DATA write
    check("rst_out", 32'(out_port), 32'h01);
    check("rst_irq", 32'(irq), 32'h0);
    rd(3'd0, rv);
    check("rst_rd0", rv, 32'h1);
    wr(3'd0, 32'h5A);
    check("data_5a", 32'(out_port), 32'h5A);

    // 2: set/clear
    wr(3'd0, 32'hF0);
    check("data_f0", 32'(out_port), 32'hF0);
    wr(3'd4, 32'h03);
    check("outset", 32'(out_port), 32'hF3);
    wr(3'd5, 32'h80);
    check("outclr", 32'(out_port), 32'h73);
    rd(3'd4, rv);
    check("rd_outset", rv, 32'h0);
    rd(3'd5, rv);
    check("rd_outclr", rv, 32'h0);

    // 3: pulse width and retrigger
    wr(3'd0, 32'h00);
    wr(3'd6, 32'h01);
    check("pulse_busy", readdata, 32'h8000_0001);
    c = 0;
    while (out_port[0] && c < 200) begin
      c++;
      @(negedge clk);
    end
    check("pulse_len", 32'(c), 32'd16);
    check("pulse_idle", readdata, 32'h0);
    check("pulse_out0", 32'(out_port), 32'h00);

    wr(3'd6, 32'h01);
    c = 0;
    repeat (9) begin
      if (out_port[0]) c++;
      @(negedge clk);
    end
    if (out_port[0]) c++;
    wr(3'd6, 32'h01);
    while (out_port[0] && c < 200) begin
      c++;
      @(negedge clk);
    end
    check("retrig_len", 32'(c), 32'd26);

    // 4: edge capture, irq, coincident W1C
    wr(3'd2, 32'h04);
    in_port = 8'h04;
    @(negedge clk);
    @(negedge clk);
    check("irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    rd(3'd3, rv);
    check("edge_cap", rv, 32'h04);
    rd(3'd1, rv);
    check("in_reg", rv, 32'h04);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h04;
    @(negedge clk);
    @(negedge clk);
    wr(3'd3, 32'h04);
    check("w1c_race_irq", 32'(irq), 32'h1);
    rd(3'd3, rv);
    check("w1c_race_cap", rv, 32'h04);
    wr(3'd3, 32'h04);
    check("w1c_irq", 32'(irq), 32'h0);
    rd(3'd3, rv);
    check("w1c_cap", rv, 32'h00);

    // 5: reset mid-pulse with state pending
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h04;
    repeat (4) @(negedge clk);
    check("pre_rst_irq", 32'(irq), 32'h1);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    wr(3'd6, 32'h80);
    check("pulse80", 32'(out_port), 32'h80);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_out", 32'(out_port), 32'h01);
    check("async_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd6, rv);
    check("rst_busy", rv, 32'h0);
    rd(3'd3, rv);
    check("rst_cap", rv, 32'h0);
    rd(3'd2, rv);
    check("rst_mask", rv, 32'h0);
    check("rst_out2", 32'(out_port), 32'h01);

    // 6: edge select / reserved address 7
    wr(3'd7, 32'h02);
    rd(3'd7, rv);
`ifdef SPW_PIO_BOTHEDGE_EN
    check("edge_sel_rd", rv, 32'h02);
`else
    check("rsvd_rd7", rv, 32'h00);
`endif
    in_port = 8'h02;
    repeat (4) @(negedge clk);
    rd(3'd1, rv);
    check("in_reg2", rv, 32'h02);
    wr(3'd3, 32'hFF);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    rd(3'd3, rv);
`ifdef SPW_PIO_BOTHEDGE_EN
    check("fall_cap", rv, 32'h02);
`else
    check("fall_nocap", rv, 32'h00);
`endif
    wr(3'd3, 32'hFF);
    wr(3'd7, 32'h00);
    in_port = 8'h02;
    repeat (4) @(negedge clk);
    wr(3'd3, 32'hFF);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    rd(3'd3, rv);
    check("fall_sel0", rv, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spw_avmm_pio_ctrl.md
Name: spw_avmm_pio_ctrl

Overview:
Parametrised Avalon-MM slave PIO for SpaceWire link control and status lines (spill enable, link start, autostart, error flags).
- Output side: W-bit output register with atomic set/clear and self-timed pulse generation.
- Input side: W-bit synchronised input with edge capture and a maskable interrupt.
- Sits between the Nios/Avalon interconnect and the SpaceWire core control pins.

Parameters:
WIDTH, 8, number of output and input bits (1..32)
RESET_VALUE, 8'h01, out_port value at reset (bit 0 = enable, asserted by default)
PULSE_CYCLES, 16, clk cycles a pulsed bit stays inverted (>=1, counter width $clog2(PULSE_CYCLES+1))
SYNC_STAGES, 2, flip-flop stages on in_port (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  read data; bits above WIDTH are zero
in_port  in  WIDTH  asynchronous status inputs
out_port  out  WIDTH  control outputs
irq  out  1  interrupt, level, active-high

Behaviour:
Write strobe = chipselect & ~write_n.
readdata is combinational from the registers (zero wait states); reads have no side effects.

Register map:
- 0 DATA, R/W: data_reg.
- 1 IN, R: synchronised in_port; writes ignored.
- 2 IRQ_MASK, R/W: reset 0.
- 3 EDGE_CAP, R/W1C: reset 0.
- 4 OUTSET, W: data_reg |= wd. Reads 0.
- 5 OUTCLR, W: data_reg &= ~wd. Reads 0.
- 6 PULSE, W: starts a pulse. Read returns {busy, pulse_mask} at bit 31 and [WIDTH-1:0].
- 7: reserved; reads 0, writes ignored.

Outputs:
- out_port = data_reg ^ (busy ? pulse_mask : 0).
- Updated on the clk edge following the write strobe (1-cycle latency); no combinational path from writedata.

Pulse state machine:
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on PULSE write with wd[WIDTH-1:0] != 0: pulse_mask <= wd, cnt <= PULSE_CYCLES.
- ACTIVE: cnt decrements each cycle; at cnt==1 -> IDLE and pulse_mask <= 0.
- Affected bits are inverted for exactly PULSE_CYCLES cycles.
- PULSE write with zero mask: ignored in both states.
- PULSE write while ACTIVE: mask replaced, cnt reloaded (retrigger); no glitch on bits common to old and new mask.
- DATA/OUTSET/OUTCLR writes during ACTIVE update data_reg; the inversion applies to the new value.

Input synchronisation:
- in_port passes through SYNC_STAGES flops to give in_sync; one further flop gives in_prev.
- Rising edge = in_sync & ~in_prev.
- Edge latency from in_port change to EDGE_CAP set = SYNC_STAGES+1 cycles.

EDGE_CAP:
- Per bit: set on edge; cleared by a write with a 1 in that bit.
- Same-cycle edge and W1C on the same bit: set wins.

irq:
- irq = |(EDGE_CAP & IRQ_MASK), driven from registered state.
- Deasserts the cycle after the clearing write (or mask write) takes effect.

Reset:
- Asynchronous assert: data_reg = RESET_VALUE[WIDTH-1:0], pulse returns to IDLE with cnt=0 and mask=0.
- Sync chain, in_prev, IRQ_MASK and EDGE_CAP reset to 0; irq = 0.
- out_port = RESET_VALUE immediately on assert, including mid-pulse.
- No edge is captured in the first cycle after release, because in_prev and in_sync both start at 0.

Optional Feature:
SPW_PIO_BOTHEDGE_EN
- Defined: a per-bit EDGE_SEL register at address 7 (R/W, reset 0). Bit=0 captures rising edges; bit=1 captures both edges (in_sync ^ in_prev).
- Undefined: rising edge only; address 7 is reserved and reads 0.

Test Plan:
1. Reset with WIDTH=8, RESET_VALUE=8'h01 -> out_port=8'h01, readdata@0=32'h1, irq=0. Write 0x5A to addr0 -> out_port=8'h5A the next cycle.
2. DATA=8'hF0; OUTSET 8'h03; OUTCLR 8'h80 -> out_port sequence F0, F3, 73. Read addr4 and addr5 -> 0.
3. DATA=8'h00; PULSE 8'h01 -> out_port bit0=1 for exactly 16 cycles; addr6 bit31=1 during the pulse, 0 after. Retrigger at cycle 10 -> high 26 cycles total.
4. IRQ_MASK=8'h04; toggle in_port[2] 0->1 -> EDGE_CAP=8'h04 and irq=1 after 3 cycles. W1C 8'h04 coincident with a new edge -> bit remains set.
5. Assert reset_n mid-pulse at cycle 5 -> out_port=8'h01 asynchronously, busy=0 after release, EDGE_CAP=0.
6. With SPW_PIO_BOTHEDGE_EN defined: EDGE_SEL=8'h02, falling edge on in_port[1] -> EDGE_CAP bit1 set. Same falling edge with EDGE_SEL=0 -> no capture.
